// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 receive frame types, frame constants and frame check helper

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  localparam int FRAME_BITS = 11;
  localparam logic START_BIT_VAL = 1'b0;
  localparam logic STOP_BIT_VAL = 1'b1;
  localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);

  // Start low, stop high, and odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return (f[0] == START_BIT_VAL) && (f[FRAME_BITS-1] == STOP_BIT_VAL) && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer and falling-edge detect for ps2_clk
// PS2_GLITCH_FILTER_EN adds a FILTER_LEN-sample stability filter before edge detect.

module ps2_line_sync
`ifdef PS2_GLITCH_FILTER_EN
  #(
    parameter int FILTER_LEN = 8
  )
`endif
  (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_fe
  );

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_line;
      r_s2 <= r_s1;
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else if (r_s2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
      r_filt <= r_s2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_fe = r_prev & ~w_level;

endmodule

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver with framing and timeout checks
// Optional clock glitch filter enabled by defining PS2_GLITCH_FILTER_EN.

module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  if (FILTER_LEN < 1) begin : g_filter_len_check
    $error("FILTER_LEN must be at least 1");
  end

  logic                  w_fe;
  logic                  r_d1;
  logic                  r_d2;
  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic [7:0]            r_code;
  logic                  r_code_valid;
  logic                  r_frame_err;
  logic                  r_timeout_err;
  logic                  r_busy;

  ps2_line_sync
`ifdef PS2_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    u_clk_sync (
      .clk    (clk),
      .rst_n  (rst),
      .i_line (ps2_clk),
      .o_fe   (w_fe)
    );

  // Data is only ever sampled at a clock edge, so it needs no filtering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d1 <= 1'b1;
      r_d2 <= 1'b1;
    end else begin
      r_d1 <= ps2_data;
      r_d2 <= r_d1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_to_cnt      <= '0;
      r_code        <= 8'h00;
      r_code_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_code_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_busy        <= (r_state != IDLE);
      case (r_state)
        IDLE: begin
          r_to_cnt <= '0;
          if (w_fe) begin
            r_shift   <= {r_d2, r_shift[FRAME_BITS-1:1]};
            r_bit_cnt <= BIT_CNT_W'(1);
            r_state   <= RECV;
          end
        end
        RECV: begin
          // An edge always wins over an expiring timeout.
          if (w_fe) begin
            r_shift   <= {r_d2, r_shift[FRAME_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_to_cnt  <= '0;
            if (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
              r_state <= CHECK;
            end
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_to_cnt      <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (frame_ok(r_shift)) begin
            r_code       <= r_shift[8:1];
            r_code_valid <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
          r_bit_cnt <= '0;
          r_to_cnt  <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign code        = r_code;
  assign code_valid  = r_code_valid;
  assign frame_err   = r_frame_err;
  assign timeout_err = r_timeout_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - scoreboard bench for ps2_rx_frame

module tb_ps2_rx_frame;

  localparam int TO   = 300;
  localparam int HALF = 20;
  localparam int FL   = 8;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int EXTRA = FL;
`else
  localparam int EXTRA = 0;
`endif

  localparam int EV_CODE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_TO   = 2;

  // {stop, parity, data[7:0], start}
  localparam logic [10:0] F_1C       = 11'b1_0_00011100_0;
  localparam logic [10:0] F_F0       = 11'b1_1_11110000_0;
  localparam logic [10:0] F_29       = 11'b1_0_00101001_0;
  localparam logic [10:0] F_1C_BPAR  = 11'b1_1_00011100_0;
  localparam logic [10:0] F_1C_BSTOP = 11'b0_0_00011100_0;
  localparam logic [10:0] F_1C_BSTRT = 11'b1_0_00011100_1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;
  logic       timeout_err;
  logic       busy;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .code        (code),
    .code_valid  (code_valid),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    int         kind;
    logic [7:0] code;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  bit   busy_fall_pending = 1'b0;
  int   got_kind;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  task automatic push_exp(input int kind, input logic [7:0] c, input int at);
    exp_t e;
    e.kind = kind;
    e.code = c;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives nbits of frame f LSB first; if kind >= 0, queues the expected event at the stop bit.
  task automatic send_frame(input logic [10:0] f, input int nbits, input int kind,
                            input logic [7:0] exp_code, output int last_c);
    last_c = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      last_c = cyc;
      if (i == 10 && kind >= 0) push_exp(kind, exp_code, cyc + 4 + EXTRA);
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (busy_fall_pending) begin
        check("busy_after_valid", busy, 0);
        busy_fall_pending = 1'b0;
      end
      if (code_valid || frame_err || timeout_err) begin
        check("pulse_exclusive", int'(code_valid) + int'(frame_err) + int'(timeout_err), 1);
        got_kind = code_valid ? EV_CODE : (frame_err ? EV_FERR : EV_TO);
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_pulse: got kind %0d code 0x%0h at cycle %0d, expected none",
                   got_kind, code, cyc);
        end else begin
          m_e = q.pop_front();
          check("event_kind", got_kind, m_e.kind);
          check("event_code", code, m_e.code);
          if (m_e.at >= 0) check("event_cycle", cyc, m_e.at);
          if (code_valid) begin
            check("busy_at_valid", busy, 1);
            busy_fall_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 60000 cycles, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b0;
    wait_cyc(5);
    check("rst_code", code, 8'h00);
    check("rst_code_valid", code_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(5);

    send_frame(F_1C, 11, EV_CODE, 8'h1C, c);
    send_frame(F_F0, 11, EV_CODE, 8'hF0, c);
    send_frame(F_1C, 11, EV_CODE, 8'h1C, c);

    send_frame(F_1C_BPAR, 11, EV_FERR, 8'h1C, c);
    send_frame(F_1C_BSTOP, 11, EV_FERR, 8'h1C, c);
    send_frame(F_1C_BSTRT, 11, EV_FERR, 8'h1C, c);
    check("code_held_after_err", code, 8'h1C);

    send_frame(F_29, 5, -1, 8'h00, c);
    push_exp(EV_TO, 8'h1C, c + 3 + EXTRA + TO);
    wait_cyc(TO + 40);
    check("busy_after_timeout", busy, 0);
    check("timeout_seen", q.size(), 0);
    send_frame(F_29, 11, EV_CODE, 8'h29, c);

    send_frame(F_1C, 7, -1, 8'h00, c);
    check("busy_midframe", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_code", code, 8'h00);
    check("midrst_code_valid", code_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_timeout_err", timeout_err, 0);
    check("midrst_busy", busy, 0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(5);
    send_frame(F_1C, 11, EV_CODE, 8'h1C, c);

    @(negedge clk);
    ps2_clk = 1'b0;
    c = cyc;
`ifndef PS2_GLITCH_FILTER_EN
    push_exp(EV_TO, 8'h1C, c + 3 + TO);
`endif
    wait_cyc(3);
    ps2_clk = 1'b1;
`ifdef PS2_GLITCH_FILTER_EN
    wait_cyc(40);
    check("glitch_busy", busy, 0);
`else
    wait_cyc(10);
    check("glitch_busy", busy, 1);
    wait_cyc(TO + 20);
    check("glitch_busy_after_to", busy, 0);
`endif

    wait_cyc(20);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
